// File: rtl/d_reg_chain.sv
// Enable-gated register chain with per-stage valid bits, fill count, clear and parallel load.
// Optional transparent bypass on q is built when D_REG_CHAIN_BYPASS_EN is defined.
module d_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic [WIDTH-1:0]       i_d,
  input  logic [WIDTH*DEPTH-1:0] i_par_d,
`ifdef D_REG_CHAIN_BYPASS_EN
  input  logic                   i_bypass,
`endif
  output logic [WIDTH-1:0]       o_q,
  output logic                   o_q_valid,
  output logic [WIDTH*DEPTH-1:0] o_taps,
  output logic [CW-1:0]          o_fill_cnt,
  output logic                   o_full
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic             r_vld   [DEPTH];
  logic [CW-1:0]    r_fill_cnt;

  logic [WIDTH-1:0] w_stage_in [DEPTH];
  logic             w_vld_in   [DEPTH];
  logic             w_fill_inc;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Stage 0 takes serial input; every later stage takes its predecessor.
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = i_d;
        assign w_vld_in[gi]   = 1'b1;
      end else begin : g_body
        assign w_stage_in[gi] = r_stage[gi-1];
        assign w_vld_in[gi]   = r_vld[gi-1];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_stage[gi] <= RESET_VAL;
          r_vld[gi]   <= 1'b0;
        end else if (i_clr) begin
          r_stage[gi] <= RESET_VAL;
          r_vld[gi]   <= 1'b0;
        end else if (i_load) begin
          r_stage[gi] <= i_par_d[gi*WIDTH +: WIDTH];
          r_vld[gi]   <= 1'b1;
        end else if (i_en) begin
          r_stage[gi] <= w_stage_in[gi];
          r_vld[gi]   <= w_vld_in[gi];
        end
      end

      assign o_taps[gi*WIDTH +: WIDTH] = r_stage[gi];
    end
  endgenerate

  // A word leaving the tail balances the word entering the head, so the count only
  // moves while the tail is still empty; the DEPTH guard keeps it from wrapping.
  assign w_fill_inc = !r_vld[DEPTH-1] && (r_fill_cnt != CW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill_cnt <= '0;
    end else if (i_clr) begin
      r_fill_cnt <= '0;
    end else if (i_load) begin
      r_fill_cnt <= CW'(DEPTH);
    end else if (i_en && w_fill_inc) begin
      r_fill_cnt <= r_fill_cnt + CW'(1);
    end
  end

  assign o_fill_cnt = r_fill_cnt;
  assign o_full     = (r_fill_cnt == CW'(DEPTH));

`ifdef D_REG_CHAIN_BYPASS_EN
  // Bypass is transparent like the old latch, but reset still forces q to RESET_VAL.
  assign o_q       = !i_rst_n ? RESET_VAL : (i_bypass ? i_d : r_stage[DEPTH-1]);
  assign o_q_valid = !i_rst_n ? 1'b0 : (i_bypass | r_vld[DEPTH-1]);
`else
  assign o_q       = r_stage[DEPTH-1];
  assign o_q_valid = r_vld[DEPTH-1];
`endif

endmodule

// File: tb/tb_d_reg_chain.sv
// Directed bench for d_reg_chain (WIDTH=8, DEPTH=4) with a queue scoreboard of shifted-in data.
module tb_d_reg_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_en;
  logic                   i_clr;
  logic                   i_load;
  logic [WIDTH-1:0]       i_d;
  logic [WIDTH*DEPTH-1:0] i_par_d;
  logic                   i_bypass;
  logic [WIDTH-1:0]       o_q;
  logic                   o_q_valid;
  logic [WIDTH*DEPTH-1:0] o_taps;
  logic [CW-1:0]          o_fill_cnt;
  logic                   o_full;

  int n_total = 0;
  int n_pass  = 0;
  int m_fill  = 0;
  logic [WIDTH-1:0] sb [$];

  always #5 i_clk = ~i_clk;

  d_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .i_load     (i_load),
    .i_d        (i_d),
    .i_par_d    (i_par_d),
`ifdef D_REG_CHAIN_BYPASS_EN
    .i_bypass   (i_bypass),
`endif
    .o_q        (o_q),
    .o_q_valid  (o_q_valid),
    .o_taps     (o_taps),
    .o_fill_cnt (o_fill_cnt),
    .o_full     (o_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic edge_step();
    @(posedge i_clk);
    #1;
  endtask

  // One enabled edge: push d, then pop the oldest word whenever the tail is valid.
  task automatic shift(input logic [WIDTH-1:0] dv);
    logic [WIDTH-1:0] exp_q;
    i_en = 1'b1;
    i_d  = dv;
    sb.push_back(dv);
    edge_step();
    if (m_fill < DEPTH) m_fill++;
    $display("shift d=%02h q=%02h q_valid=%0b fill=%0d", dv, o_q, o_q_valid, o_fill_cnt);
    chk("fill_cnt", 64'(o_fill_cnt), 64'(m_fill));
    chk("full", 64'(o_full), 64'(m_fill == DEPTH));
    chk("q_valid", 64'(o_q_valid), 64'(m_fill == DEPTH));
    if (m_fill == DEPTH && sb.size() > 0) begin
      exp_q = sb.pop_front();
      chk("q_data", 64'(o_q), 64'(exp_q));
    end
    i_en = 1'b0;
  endtask

  task automatic hold(input int n);
    i_en = 1'b0;
    repeat (n) edge_step();
    $display("hold %0d edges fill=%0d taps=%08h", n, o_fill_cnt, o_taps);
    chk("hold_fill", 64'(o_fill_cnt), 64'(m_fill));
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_clr = 1'b0; i_load = 1'b0;
    i_d = 8'hFF; i_par_d = '0; i_bypass = 1'b0;

    // 1. reset held across enabled edges
    repeat (3) edge_step();
    $display("reset q=%02h q_valid=%0b fill=%0d taps=%08h", o_q, o_q_valid, o_fill_cnt, o_taps);
    chk("rst_q", 64'(o_q), 64'h00);
    chk("rst_q_valid", 64'(o_q_valid), 64'h0);
    chk("rst_fill", 64'(o_fill_cnt), 64'h0);
    chk("rst_taps", 64'(o_taps), 64'h0);
    chk("rst_full", 64'(o_full), 64'h0);
    i_rst_n = 1'b1; i_en = 1'b0;

    // 2. fill and latency
    shift(8'h11); shift(8'h22); shift(8'h33); shift(8'h44);
    chk("fill_taps", 64'(o_taps), 64'h11223344);
    shift(8'h55);

    // 3. stall keeps contents and order
    i_clr = 1'b1; edge_step(); i_clr = 1'b0;
    sb.delete(); m_fill = 0;
    chk("clr_taps", 64'(o_taps), 64'h0);
    chk("clr_fill", 64'(o_fill_cnt), 64'h0);
    shift(8'hA1); shift(8'hA2);
    hold(5);
    chk("stall_taps", 64'(o_taps), 64'h0000A1A2);
    shift(8'hA3); shift(8'hA4); shift(8'hA5);

    // 4. priority: load over en, clr over load
    i_load = 1'b1; i_par_d = 32'hDDCCBBAA; i_en = 1'b1; i_d = 8'h99;
    edge_step();
    $display("load taps=%08h q=%02h fill=%0d", o_taps, o_q, o_fill_cnt);
    chk("load_taps", 64'(o_taps), 64'hDDCCBBAA);
    chk("load_q", 64'(o_q), 64'hDD);
    chk("load_fill", 64'(o_fill_cnt), 64'd4);
    chk("load_q_valid", 64'(o_q_valid), 64'h1);
    i_clr = 1'b1;
    edge_step();
    i_clr = 1'b0; i_load = 1'b0; i_en = 1'b0;
    $display("clr+load taps=%08h fill=%0d", o_taps, o_fill_cnt);
    chk("clrload_taps", 64'(o_taps), 64'h0);
    chk("clrload_fill", 64'(o_fill_cnt), 64'h0);
    chk("clrload_q_valid", 64'(o_q_valid), 64'h0);
    sb.delete(); m_fill = 0;

    // 5. asynchronous reset between edges
    shift(8'h61); shift(8'h62); shift(8'h63); shift(8'h64);
    i_en = 1'b1; i_d = 8'h65;
    #3 i_rst_n = 1'b0;
    #1;
    $display("async reset q=%02h q_valid=%0b taps=%08h fill=%0d", o_q, o_q_valid, o_taps, o_fill_cnt);
    chk("arst_q", 64'(o_q), 64'h0);
    chk("arst_q_valid", 64'(o_q_valid), 64'h0);
    chk("arst_taps", 64'(o_taps), 64'h0);
    chk("arst_fill", 64'(o_fill_cnt), 64'h0);
    i_rst_n = 1'b1; i_en = 1'b0;
    sb.delete(); m_fill = 0;
    shift(8'h77);
    chk("post_rst_taps", 64'(o_taps), 64'h00000077);

`ifdef D_REG_CHAIN_BYPASS_EN
    // 6. transparent bypass between edges
    i_en = 1'b0; i_bypass = 1'b1; i_d = 8'h0F;
    #1 chk("byp_q_0f", 64'(o_q), 64'h0F);
    chk("byp_valid", 64'(o_q_valid), 64'h1);
    i_d = 8'hF0;
    #1 chk("byp_q_f0", 64'(o_q), 64'hF0);
    chk("byp_taps", 64'(o_taps), 64'h00000077);
    $display("bypass q=%02h q_valid=%0b", o_q, o_q_valid);
    i_bypass = 1'b0;
    #1 chk("byp_off_q", 64'(o_q), 64'h00);
    chk("byp_off_valid", 64'(o_q_valid), 64'h0);
    edge_step();
    chk("byp_fill", 64'(o_fill_cnt), 64'd1);
`endif

    // random enabled/stalled traffic through the scoreboard
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) != 0) shift(8'($urandom_range(0, 255)));
      else hold(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/d_reg_chain.md
# d_reg_chain

Parametrised, clock-enabled data register chain and the synchronous successor to the level-sensitive D latch. Data advances one stage per enabled clock. Each stage carries a valid bit and the block keeps a running fill count. The block also supports synchronous clear, parallel load of every stage, and a configurable depth. It sits between a producer and any consumer that needs a fixed, enable-gated delay with visibility into every stage.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of stages (≥2)
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset or clear

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  shift enable
- clr  input  1  synchronous clear
- load  input  1  synchronous parallel load
- d  input  WIDTH  serial data into stage 0
- par_d  input  WIDTH*DEPTH  parallel load data; stage i = par_d[i*WIDTH +: WIDTH]
- bypass  input  1  transparent bypass; exists only with D_REG_CHAIN_BYPASS_EN
- q  output  WIDTH  stage DEPTH-1 data
- q_valid  output  1  valid bit of stage DEPTH-1
- taps  output  WIDTH*DEPTH  all stage data; stage i at [i*WIDTH +: WIDTH]
- fill_cnt  output  $clog2(DEPTH+1)  number of valid stages
- full  output  1  fill_cnt == DEPTH

## Operation
- State:
  - stage[0..DEPTH-1], WIDTH bits each
  - vld[0..DEPTH-1], 1 bit each
  - fill_cnt register
- Per-edge priority, highest first: clr > load > en > hold.
- clr: all stages = RESET_VAL, all vld = 0, fill_cnt = 0.
- load: stage[i] = par_d slice i, all vld = 1, fill_cnt = DEPTH. en is ignored.
- en (no clr, no load):
  - stage[0] = d, vld[0] = 1.
  - stage[i] = stage[i-1] and vld[i] = vld[i-1] for i ≥ 1.
  - The stage DEPTH-1 contents are discarded.
- fill_cnt update on en:
  - Increments when vld[DEPTH-1] was 0 before the edge.
  - Unchanged when vld[DEPTH-1] was 1 (one in, one out).
  - Saturates at DEPTH and never wraps.
- Hold: when en, clr and load are all 0, all state is unchanged.
- full is combinational from fill_cnt.

## Timing
- All registers are reset asynchronously on reset falling, with no clock required:
  - stages = RESET_VAL, vld = 0, fill_cnt = 0
  - q = RESET_VAL, q_valid = 0, taps = {DEPTH{RESET_VAL}}, full = 0
- Release of reset is synchronous: the first edge with reset = 1 acts normally.
- Latency from d to q is exactly DEPTH enabled edges. Cycles with en = 0 add delay but lose no data.
- taps, q and q_valid are registered outputs; they change only on clk rising or on reset.
- Reset asserted mid-operation discards all contents immediately; no partial shift occurs.
- clr, load and en are sampled only at rising edges. No glitch-driven behaviour is permitted.

## Configuration
- D_REG_CHAIN_BYPASS_EN defined:
  - The bypass port exists.
  - When bypass = 1, q = d and q_valid = 1 combinationally, giving latch-style transparent behaviour.
  - The internal chain keeps operating normally; taps and fill_cnt are unaffected by bypass.
  - During reset, q = RESET_VAL regardless of bypass.
- Not defined:
  - The bypass port is absent.
  - q is always stage DEPTH-1.

## Test plan
1. Reset: hold reset = 0 with d = 8'hFF and en = 1 for 3 edges -> q = 8'h00, q_valid = 0, fill_cnt = 0, taps = 32'h0. Assert reset between edges -> outputs clear immediately.
2. Fill and latency (WIDTH = 8, DEPTH = 4): en = 1, d = 8'h11, 8'h22, 8'h33, 8'h44 on successive edges:
   - fill_cnt = 1, 2, 3, 4
   - q = 8'h11 and q_valid = 1 after edge 4; full = 1
   - a fifth edge with d = 8'h55 -> q = 8'h22, fill_cnt stays 4
3. Stall: after two enabled edges, hold en = 0 for 5 edges -> taps unchanged and fill_cnt = 2. Resume -> data order preserved.
4. Priority: load = 1, par_d = 32'hDDCCBBAA, en = 1, d = 8'h99 -> taps = 32'hDDCCBBAA, q = 8'hDD, fill_cnt = 4. Next edge with clr = 1, load = 1 -> all zero, fill_cnt = 0.
5. Mid-shift reset: with full chain and en = 1, drop reset for 1 ns away from a clock edge -> q = 0 and q_valid = 0 immediately. Next enabled edge after release -> fill_cnt = 1.
6. Bypass (macro defined): bypass = 1, d toggled 8'h0F/8'hF0 with en = 0 -> q follows d with no clock edge and q_valid = 1. bypass = 0 -> q returns to stage 3 value.
